// File: rtl/ldst_control_unit.sv
// Control sequencer for the DataPath. It runs the fetch cycle, decodes the IR opcode and
// steps through the ld/ldi/st/nop/halt micro-steps, waiting on mem_ready for memory accesses.
module ldst_control_unit #(
  parameter logic [4:0]  ADD_OP = 5'b00011,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             RZin,
  output logic             RZLOout,
  output logic             PCin,
  output logic             Read,
  output logic             Write,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             grb,
  output logic             gra,
  output logic             rin,
  output logic             rout,
  output logic             BAout,
  output logic             RYin,
  output logic             Cout,
  output logic [4:0]       ops,
  output logic             run,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    INIT = 4'd0, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  typedef enum logic [2:0] {
    K_LD = 3'd0, K_LDI, K_ST, K_NOP, K_HALT, K_ILL
  } kind_t;

  function automatic kind_t classify(input logic [4:0] op);
    kind_t k;
    case (op)
      5'b00000: k = K_LD;
      5'b00001: k = K_LDI;
      5'b00010: k = K_ST;
      5'b11010: k = K_NOP;
      5'b11011: k = K_HALT;
      default:  k = K_ILL;
    endcase
    return k;
  endfunction

  state_t           state_r;
  state_t           next_s;
  kind_t            kind_r;
  kind_t            op_kind_s;
  logic             retire_s;
  logic             mem_op_s;
  logic [CNT_W-1:0] count_r;

  assign op_kind_s   = classify(ir[31:27]);
  assign mem_op_s    = (op_kind_s == K_LD) || (op_kind_s == K_LDI) || (op_kind_s == K_ST);
  assign instr_count = count_r;

  // Next-state selection and detection of the edge that retires an instruction
  always_comb begin
    next_s   = state_r;
    retire_s = 1'b0;
    case (state_r)
      INIT: next_s = T0;
      T0:   next_s = T1;
      T1:   if (mem_ready) next_s = T2; else next_s = T1;
      T2:   next_s = T3;
      T3: begin
        case (op_kind_s)
          K_LD, K_LDI, K_ST: next_s = T4;
          K_NOP:  begin next_s = T0;   retire_s = 1'b1; end
          K_HALT: begin next_s = HALT; retire_s = 1'b1; end
          default: next_s = T0;
        endcase
      end
      T4:   next_s = T5;
      T5:   if (kind_r == K_LDI) begin next_s = T0; retire_s = 1'b1; end else next_s = T6;
      // only ld waits in T6; st waits for its Write in T7
      T6:   if ((kind_r == K_ST) || mem_ready) next_s = T7; else next_s = T6;
      T7:   if (mem_ready) begin next_s = T0; retire_s = 1'b1; end else next_s = T7;
      HALT: next_s = HALT;
      default: next_s = INIT;
    endcase
  end

  // State, latched instruction class and retired-instruction counter
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_r <= INIT;
      kind_r  <= K_NOP;
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_s;
      if (state_r == T3) kind_r <= op_kind_s; else kind_r <= kind_r;
      if (retire_s) count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else          count_r <= count_r;
    end
  end

  // Strobe decode from the current state (the IR class is only consulted from T3 onward)
  always_comb begin
    {PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, Write, MDRin, MDRout, IRin} = 11'b0;
    {grb, gra, rin, rout, BAout, RYin, Cout, illegal} = 8'b0;
    ops = 5'b00000;
    run = (state_r != INIT) && (state_r != HALT);
    case (state_r)
      T0: {PCout, MARin, IncPC, RZin} = 4'b1111;
      T1: {RZLOout, PCin, Read, MDRin} = 4'b1111;
      T2: {MDRout, IRin} = 2'b11;
      T3: begin
        if (mem_op_s) {grb, BAout, RYin} = 3'b111;
        else if (op_kind_s == K_ILL) illegal = 1'b1;
        else illegal = 1'b0;
      end
      T4: begin
        {Cout, RZin} = 2'b11;
        ops = ADD_OP;
      end
      T5: begin
        RZLOout = 1'b1;
        if (kind_r == K_LDI) {gra, rin} = 2'b11; else MARin = 1'b1;
      end
      T6: if (kind_r == K_ST) {gra, rout, MDRin} = 3'b111; else {Read, MDRin} = 2'b11;
      T7: if (kind_r == K_ST) Write = 1'b1; else {MDRout, gra, rin} = 3'b111;
      default: run = run;
    endcase
  end

endmodule

// File: tb/tb_ldst_control_unit.sv
// Bench for ldst_control_unit: a micro-program table model checked every cycle, plus
// directed instruction vectors with hand-computed cycle counts and counter values.
module tb_ldst_control_unit;

  logic        clock, clear, mem_ready;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, Write, MDRin, MDRout, IRin;
  logic grb, gra, rin, rout, BAout, RYin, Cout, run, illegal;
  logic [4:0] ops;
  logic [3:0] instr_count;

  ldst_control_unit #(.ADD_OP(5'b00011), .CNT_W(4)) dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin), .RZLOout(RZLOout),
    .PCin(PCin), .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .grb(grb), .gra(gra), .rin(rin), .rout(rout), .BAout(BAout), .RYin(RYin), .Cout(Cout),
    .ops(ops), .run(run), .illegal(illegal), .instr_count(instr_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  localparam logic [18:0] M_PCOUT = 19'h40000, M_MARIN = 19'h20000, M_INCPC = 19'h10000;
  localparam logic [18:0] M_RZIN = 19'h08000, M_RZLO = 19'h04000, M_PCIN = 19'h02000;
  localparam logic [18:0] M_READ = 19'h01000, M_WRITE = 19'h00800, M_MDRIN = 19'h00400;
  localparam logic [18:0] M_MDROUT = 19'h00200, M_IRIN = 19'h00100, M_GRB = 19'h00080;
  localparam logic [18:0] M_GRA = 19'h00040, M_RIN = 19'h00020, M_ROUT = 19'h00010;
  localparam logic [18:0] M_BAOUT = 19'h00008, M_RYIN = 19'h00004, M_COUT = 19'h00002;
  localparam logic [18:0] M_ILL = 19'h00001;
  localparam int KLD = 0, KLDI = 1, KST = 2, KNOP = 3, KILL = 4, KHALT = 5;

  logic [18:0] dut_vec;
  assign dut_vec = {PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, Write, MDRin, MDRout,
                    IRin, grb, gra, rin, rout, BAout, RYin, Cout, illegal};

  // micro-program per instruction class: strobes, ops and whether the step waits for memory
  logic [18:0] prog [0:5][0:7];
  logic [4:0]  opsv [0:5][0:7];
  bit          wt   [0:5][0:7];
  int          len  [0:5];

  int checks = 0, errors = 0;
  bit started = 0;
  int m_phase = 0, m_idx = 0, m_kind = KNOP;
  logic [3:0] m_cnt = 4'd0;

  function automatic int cls(input logic [4:0] op);
    case (op)
      5'b00000: return KLD;
      5'b00001: return KLDI;
      5'b00010: return KST;
      5'b11010: return KNOP;
      5'b11011: return KHALT;
      default:  return KILL;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) begin
        prog[k][i] = 19'h0; opsv[k][i] = 5'b00000; wt[k][i] = 1'b0;
      end
      prog[k][0] = M_PCOUT | M_MARIN | M_INCPC | M_RZIN;
      prog[k][1] = M_RZLO | M_PCIN | M_READ | M_MDRIN;
      wt[k][1]   = 1'b1;
      prog[k][2] = M_MDROUT | M_IRIN;
      if (k <= KST) begin
        prog[k][3] = M_GRB | M_BAOUT | M_RYIN;
        prog[k][4] = M_COUT | M_RZIN;
        opsv[k][4] = 5'b00011;
      end
    end
    prog[KLDI][5] = M_RZLO | M_GRA | M_RIN;
    prog[KLD][5]  = M_RZLO | M_MARIN;
    prog[KLD][6]  = M_READ | M_MDRIN;  wt[KLD][6] = 1'b1;
    prog[KLD][7]  = M_MDROUT | M_GRA | M_RIN;
    prog[KST][5]  = M_RZLO | M_MARIN;
    prog[KST][6]  = M_GRA | M_ROUT | M_MDRIN;
    prog[KST][7]  = M_WRITE;           wt[KST][7] = 1'b1;
    prog[KILL][3] = M_ILL;
    len[KLD] = 8; len[KLDI] = 6; len[KST] = 8; len[KNOP] = 4; len[KILL] = 4; len[KHALT] = 4;
  end

  // model: advances on each rising edge using the inputs held before it
  initial begin
    forever begin
      @(posedge clock);
      if (!clear) begin
        m_phase = 0; m_idx = 0; m_cnt = 4'd0;
      end else if (m_phase == 0) begin
        m_phase = 1; m_idx = 0;
      end else if (m_phase == 1) begin
        if (!(wt[m_kind][m_idx] && !mem_ready)) begin
          if (m_idx == len[m_kind] - 1) begin
            if (m_kind != KILL) m_cnt = m_cnt + 4'd1;
            if (m_kind == KHALT) m_phase = 2;
            m_idx = 0;
          end else begin
            m_idx++;
            if (m_idx == 3) m_kind = cls(ir[31:27]);
          end
        end
      end
      started = 1;
    end
  end

  // compare the DUT against the model on every falling edge
  initial begin
    forever begin
      @(negedge clock);
      if (started) begin
        if (m_phase == 1) begin
          check("strobes", {13'b0, dut_vec}, {13'b0, prog[m_kind][m_idx]});
          check("ops", {27'b0, ops}, {27'b0, opsv[m_kind][m_idx]});
          check("run", {31'b0, run}, 32'd1);
        end else begin
          check("strobes_idle", {13'b0, dut_vec}, 32'd0);
          check("ops_idle", {27'b0, ops}, 32'd0);
          check("run_idle", {31'b0, run}, 32'd0);
        end
        check("instr_count", {28'b0, instr_count}, {28'b0, m_cnt});
        check("rd_wr_excl", {31'b0, Read & Write}, 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // run one instruction for n cycles starting at its T0, with mem_ready low in a window
  task automatic do_instr(input logic [31:0] word, input int n, input int lo_s, input int lo_n,
                          output int reads, output int writes, output int ills,
                          output int addc, output int garin);
    ir = word;
    reads = 0; writes = 0; ills = 0; addc = 0; garin = 0;
    for (int k = 0; k < n; k++) begin
      mem_ready = (k >= lo_s && k < lo_s + lo_n) ? 1'b0 : 1'b1;
      reads  += int'(Read);
      writes += int'(Write);
      ills   += int'(illegal);
      addc   += int'(ops == 5'b00011);
      garin  += int'(gra & rin);
      cyc();
    end
    mem_ready = 1'b1;
  endtask

  int rd, wr, il, ad, gr;

  initial begin
    clear = 1'b0; mem_ready = 1'b1; ir = 32'h0;
    repeat (2) cyc();
    check("reset_run", {31'b0, run}, 32'd0);
    check("reset_count", {28'b0, instr_count}, 32'd0);
    check("reset_pcout", {31'b0, PCout}, 32'd0);
    clear = 1'b1;
    cyc();
    check("t0_after_reset", {31'b0, PCout & MARin & IncPC & RZin}, 32'd1);

    do_instr(32'h09000005, 6, 0, 0, rd, wr, il, ad, gr);
    check("ldi_count", {28'b0, instr_count}, 32'd1);
    check("ldi_addop_cycles", ad, 32'd1);
    check("ldi_gra_rin", gr, 32'd1);
    check("ldi_t0_next", {31'b0, PCout}, 32'd1);

    do_instr(32'h00900054, 11, 6, 3, rd, wr, il, ad, gr);
    check("ld_count", {28'b0, instr_count}, 32'd2);
    check("ld_read_cycles", rd, 32'd5);
    check("ld_gra_rin", gr, 32'd1);

    do_instr(32'h12080087, 8, 0, 0, rd, wr, il, ad, gr);
    check("st_count", {28'b0, instr_count}, 32'd3);
    check("st_write_cycles", wr, 32'd1);
    check("st_read_cycles", rd, 32'd1);

    do_instr(32'h09000005, 7, 1, 1, rd, wr, il, ad, gr);
    check("ldi_t1wait_count", {28'b0, instr_count}, 32'd4);
    check("ldi_t1wait_reads", rd, 32'd2);

    do_instr(32'hF8000000, 4, 0, 0, rd, wr, il, ad, gr);
    check("illegal_pulses", il, 32'd1);
    check("illegal_count", {28'b0, instr_count}, 32'd4);

    do_instr(32'hD8000000, 4, 0, 0, rd, wr, il, ad, gr);
    check("halt_count", {28'b0, instr_count}, 32'd5);
    for (int i = 0; i < 20; i++) begin
      check("halt_run", {31'b0, run}, 32'd0);
      cyc();
    end
    check("halt_count_hold", {28'b0, instr_count}, 32'd5);

    // reset in the middle of a stalled fetch
    clear = 1'b0; cyc();
    clear = 1'b1; ir = 32'hD0000000; cyc();
    mem_ready = 1'b0; cyc();
    check("t1_stall_read", {31'b0, Read}, 32'd1);
    clear = 1'b0; cyc();
    check("midreset_read", {31'b0, Read}, 32'd0);
    check("midreset_count", {28'b0, instr_count}, 32'd0);
    check("midreset_run", {31'b0, run}, 32'd0);
    clear = 1'b1; mem_ready = 1'b1; cyc();

    for (int i = 0; i < 15; i++) do_instr(32'hD0000000, 4, 0, 0, rd, wr, il, ad, gr);
    check("nop_count15", {28'b0, instr_count}, 32'd15);
    do_instr(32'hD0000000, 4, 0, 0, rd, wr, il, ad, gr);
    check("nop_wrap", {28'b0, instr_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldst_control_unit.md
# ldst_control_unit

Control sequencer that drives the DataPath's control inputs in place of hand-written testbench sequencing. It runs the fetch cycle (T0–T2), decodes the opcode in IR, and steps through the execute micro-steps for `ld`, `ldi`, `st`, `nop` and `halt`. It waits on a memory-ready handshake for every Read and Write. It sits directly upstream of DataPath: every output below connects to the DataPath port of the same name.

## Interface
Parameters:
- ADD_OP, 5'b00011: ALU op code placed on `ops` for address calculation.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- clear  in  1  synchronous, active-low reset: sampled on the rising edge of clock; 0 = reset.
- ir  in  32  IR contents from DataPath. Fields: op=[31:27], ra=[26:23], rb=[22:19], C=[18:0].
- mem_ready  in  1  memory has completed the current Read/Write this cycle.
- PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, Write, MDRin, MDRout, IRin  out  1 each  DataPath strobes.
- grb, gra, rin, rout, BAout, RYin, Cout  out  1 each  DataPath register-select and bus strobes.
- ops  out  5  ALU operation.
- run  out  1  1 while sequencing; 0 in INIT and HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- instr_count  out  CNT_W  number of retired instructions.

## Operation
- States: INIT, T0–T7, HALT. State is a registered variable.
- Control outputs are decoded from state only (Moore). Every signal not listed for a state is 0. `ops` is 0 outside T4.
- Reset (clear=0 at an edge, from any state):
  - state<=INIT, instr_count<=0.
  - In INIT all outputs are 0.
  - INIT->T0 unconditionally on the next edge with clear=1.
- Fetch:
  - T0: PCout, MARin, IncPC, RZin.
  - T1: RZLOout, PCin, Read, MDRin. Stay in T1 while mem_ready=0. Repeating PCin is idempotent because RZ is unchanged.
  - T2: MDRout, IRin.
- Decode in T3, on ir[31:27]:
  - 00000 = ld
  - 00001 = ldi
  - 00010 = st
  - 11010 = nop
  - 11011 = halt
  - any other value is illegal
- ld / ldi / st share T3–T4:
  - T3: grb, BAout, RYin.
  - T4: Cout, RZin, ops=ADD_OP.
- ldi: T5: RZLOout, gra, rin; then ->T0.
- ld:
  - T5: RZLOout, MARin.
  - T6: Read, MDRin; hold until mem_ready=1.
  - T7: MDRout, gra, rin; then ->T0.
- st:
  - T5: RZLOout, MARin.
  - T6: gra, rout, MDRin (Read=0, so MDR loads from the bus).
  - T7: Write; hold until mem_ready=1; then ->T0.
- nop: T3 asserts nothing, ->T0.
- Illegal opcode: T3 asserts illegal, ->T0. Not counted as retired.
- halt: T3->HALT. HALT is absorbing; only clear=0 leaves it. In HALT run=0 and all strobes are 0.
- instr_count increments by 1 on the edge leaving the final state of ld, ldi, st, nop or halt. It wraps from 2^CNT_W-1 to 0.
- Read and Write are never asserted in the same cycle.

## Timing
- Minimum cycles per instruction, including fetch, with mem_ready tied to 1: ldi 6, ld 8, st 8, nop 4, halt 4 to reach HALT.
- Each cycle of mem_ready=0 in T1, ld-T6 or st-T7 adds exactly one cycle. No other state samples mem_ready.
- mem_ready arriving in the same cycle the wait state is entered lets the state exit on the next edge (zero wait).
- Reset mid-operation: strobes drop to 0 within one cycle of the clear edge. No partial completion, no count increment.
- clear=0 held: state remains INIT. First T0 occurs one cycle after the first edge with clear=1.
- A Read or Write still asserted at reset is abandoned; memory must tolerate this.

## Test plan
- Reset then ldi: clear=0 for 2 cycles, ir=0x09000005 (ldi R2,0x5(R0)), mem_ready=1 -> T0..T5 in 6 cycles. ops=00011 only in T4; gra&rin in T5; instr_count=1.
- ld with wait: ir=0x00900054 (ld R1,0x54(R2)), mem_ready low 3 cycles in T6 -> Read&MDRin held 4 cycles; total 11 cycles; T7 asserts MDRout,gra,rin.
- st: ir=0x12080087 (st 0x87(R1),R4), mem_ready=1 -> T6 asserts gra,rout,MDRin with Read=0; T7 asserts Write for exactly 1 cycle; Read never 1 in T5–T7.
- halt and illegal: ir=0xF8000000 -> illegal pulses once in T3, count unchanged. Then ir=0xD8000000 -> HALT, run=0 stays 0 for 20 cycles, count +1.
- Reset mid-fetch: clear=0 during T1 with mem_ready=0 -> next cycle state INIT, Read=0, instr_count=0. Restart fetch completes normally.
- Counter wrap with CNT_W=4: 16 nops -> instr_count returns to 0.
